// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader.
//   - state_t          : loader FSM states (readback states exist only when
//                        PROG_LOADER_READBACK_EN is defined)
//   - SYNC_BYTE        : frame start marker
//   - FRAME_HDR_BYTES  : sync + two length bytes
//   - WORD_COUNT_BITS  : width of the words_written / length counters
//   - word_count_width : bits needed to hold a word count up to max_words
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         FRAME_HDR_BYTES = 3;
    localparam int         WORD_COUNT_BITS = 13;

    typedef enum logic [3:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef PROG_LOADER_READBACK_EN
        RB_REQ,
        RB_CHK,
`endif
        CSUM,
        DONE,
        ERR
    } state_t;

    function automatic int word_count_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte idle timer for the boot loader.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : an accepted byte this cycle, restarts the idle count
//   enable     : loader is inside a frame and waiting for bytes
//   expired    : this cycle is the TIMEOUT_CYCLES-th consecutive idle cycle
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    // count_reg holds the number of idle cycles already completed, so the
    // count reaches TIMEOUT_CYCLES at the end of the cycle where it equals
    // TIMEOUT_CYCLES-1; flagging that cycle lets the FSM leave exactly then.
    assign expired = enable && !clear && (count_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear || !enable) begin
            count_reg <= '0;
        end else if (!expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream boot loader in front of the program memory data port.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes (little-endian words), CSUM
// where CSUM is the XOR of all data bytes. The CPU is held in reset until a
// frame with a good checksum has been stored.
// Optional feature macro: PROG_LOADER_READBACK_EN (read back and verify each
// written word before accepting more bytes).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_data/valid/ready   byte input, transfer on rx_valid & rx_ready
//   mem_address/wen/ren   program memory word address and strobes
//   mem_data_in           word to write, mem_byte_select byte enables
//   mem_data_out          read data, valid one cycle after mem_ren
//   cpu_reset_hold        1 keeps the core in reset
//   load_done/load_error  frame accepted / rejected
//   words_written         words written in the current frame
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [29:0] BASE_WORD_ADDR = 30'd0,
    parameter int          MAX_WORDS      = 4096,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [29:0] mem_address,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_byte_select,
    input  logic [31:0] mem_data_out,
    output logic        cpu_reset_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [12:0] words_written
);

    localparam logic [63:0] LAST_WORD_ADDR = 64'(BASE_WORD_ADDR) + 64'(MAX_WORDS) - 64'd1;

    generate
        if (LAST_WORD_ADDR > 64'h3FFF_FFFF) begin : g_addr_wrap_check
            $error("prog_loader: BASE_WORD_ADDR + MAX_WORDS - 1 wraps the 30-bit word address");
        end
        if (word_count_width(MAX_WORDS) > WORD_COUNT_BITS) begin : g_count_width_check
            $error("prog_loader: MAX_WORDS does not fit the word counter");
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [7:0]  len_lo_reg, len_lo_next;
    logic [12:0] len_reg, len_next;
    logic [12:0] idx_reg, idx_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [31:0] word_reg, word_next;
    logic [7:0]  csum_reg, csum_next;
    logic        hold_reg, hold_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;

    logic        accepted;
    logic        in_frame;
    logic        expired;
    logic [15:0] len_full;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accepted),
        .enable  (in_frame),
        .expired (expired)
    );

`ifdef PROG_LOADER_READBACK_EN
    assign rx_ready = !(state_reg inside {WRITE, RB_REQ, RB_CHK});
    assign mem_ren  = (state_reg == RB_REQ);
`else
    logic unused_read_data;
    assign unused_read_data = ^mem_data_out;
    assign rx_ready = (state_reg != WRITE);
    assign mem_ren  = 1'b0;
`endif

    assign accepted = rx_valid && rx_ready;
    assign in_frame = state_reg inside {LEN0, LEN1, DATA, CSUM};
    assign len_full = {rx_data, len_lo_reg};

    assign mem_wen         = (state_reg == WRITE);
    assign mem_data_in     = mem_wen ? word_reg : 32'd0;
    assign mem_byte_select = mem_wen ? 4'hF : 4'h0;

    always_comb begin
        mem_address = 30'd0;
        if (state_reg == WRITE) begin
            mem_address = BASE_WORD_ADDR + 30'(idx_reg);
        end
`ifdef PROG_LOADER_READBACK_EN
        // idx has already advanced past the word being verified.
        if (state_reg == RB_REQ) begin
            mem_address = BASE_WORD_ADDR + 30'(idx_reg) - 30'd1;
        end
`endif
    end

    assign cpu_reset_hold = hold_reg;
    assign load_done      = done_reg;
    assign load_error     = error_reg;
    assign words_written  = idx_reg;

    always_comb begin
        state_next    = state_reg;
        len_lo_next   = len_lo_reg;
        len_next      = len_reg;
        idx_next      = idx_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        csum_next     = csum_reg;
        hold_next     = hold_reg;
        done_next     = done_reg;
        error_next    = error_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (accepted && rx_data == SYNC_BYTE) begin
                    state_next    = LEN0;
                    idx_next      = '0;
                    byte_idx_next = '0;
                    csum_next     = '0;
                    hold_next     = 1'b1;
                    done_next     = 1'b0;
                    error_next    = 1'b0;
                end
            end
            LEN0: begin
                if (expired) begin
                    state_next = ERR;
                    error_next = 1'b1;
                end else if (accepted) begin
                    len_lo_next = rx_data;
                    state_next  = LEN1;
                end
            end
            LEN1: begin
                if (expired) begin
                    state_next = ERR;
                    error_next = 1'b1;
                end else if (accepted) begin
                    len_next = len_full[12:0];
                    if (32'(len_full) > MAX_WORDS) begin
                        state_next = ERR;
                        error_next = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    state_next = ERR;
                    error_next = 1'b1;
                end else if (accepted) begin
                    word_next[8*byte_idx_reg +: 8] = rx_data;
                    csum_next     = csum_reg ^ rx_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_next = idx_reg + 13'd1;
`ifdef PROG_LOADER_READBACK_EN
                state_next = RB_REQ;
`else
                state_next = (idx_reg + 13'd1 == len_reg) ? CSUM : DATA;
`endif
            end
`ifdef PROG_LOADER_READBACK_EN
            RB_REQ: begin
                state_next = RB_CHK;
            end
            RB_CHK: begin
                if (mem_data_out != word_reg) begin
                    state_next = ERR;
                    error_next = 1'b1;
                end else begin
                    state_next = (idx_reg == len_reg) ? CSUM : DATA;
                end
            end
`endif
            CSUM: begin
                if (expired) begin
                    state_next = ERR;
                    error_next = 1'b1;
                end else if (accepted) begin
                    if (rx_data == csum_reg) begin
                        state_next = DONE;
                        hold_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ERR;
                        error_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_lo_reg   <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            csum_reg     <= '0;
            hold_reg     <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_lo_reg   <= len_lo_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            csum_reg     <= csum_next;
            hold_reg     <= hold_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued when a
// frame is issued and popped by a monitor on every mem_wen; status outputs
// are checked directly after each frame.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam logic [29:0] BASE = 30'h100;
    localparam int          TMO  = 16;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] mem_address;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_byte_select;
    logic [31:0] mem_data_out;
    logic        cpu_reset_hold;
    logic        load_done;
    logic        load_error;
    logic [12:0] words_written;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    logic ren_seen = 1'b0;
    logic corrupt  = 1'b0;
    logic [31:0] mem [64];
    logic [7:0]  bytes[$];

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_WORD_ADDR (BASE),
        .MAX_WORDS      (4096),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .mem_address     (mem_address),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_data_in     (mem_data_in),
        .mem_byte_select (mem_byte_select),
        .mem_data_out    (mem_data_out),
        .cpu_reset_hold  (cpu_reset_hold),
        .load_done       (load_done),
        .load_error      (load_error),
        .words_written   (words_written)
    );

    // Program memory model; readback of BASE+1 can be corrupted on demand.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_address[5:0]] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem[mem_address[5:0]] ^ ((corrupt && mem_address == BASE + 30'd1) ? 32'h1 : 32'h0);
    end

    // Monitor: pops one expected write per mem_wen.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_ren) ren_seen = 1'b1;
            if (mem_wen && mem_ren) begin
                n_checks++; n_fail++;
                $display("FAIL wen_ren_overlap: both strobes high at %0t", $time);
            end
            if (mem_wen) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_address, mem_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_address != e.addr || mem_data_in != e.data || mem_byte_select != 4'hF) begin
                        n_fail++;
                        $display("FAIL mem_write: addr=%h data=%h be=%h, required addr=%h data=%h be=f",
                                 mem_address, mem_data_in, mem_byte_select, e.addr, e.data);
                    end else begin
                        $display("write ok: addr=%h data=%h", mem_address, mem_data_in);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!rx_ready) begin
            n_checks++; n_fail++;
            $display("FAIL rx_ready_timeout: rx_ready=0 for %0d cycles, required 1", guard);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic expect_write(input logic [29:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic good_frame();
        expect_write(BASE,         32'h44332211);
        expect_write(BASE + 30'd1, 32'h88776655);
        bytes = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_seq(bytes);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic hold, input logic [12:0] words);
        check({tag, "_load_done"},     32'(load_done),      32'(done));
        check({tag, "_load_error"},    32'(load_error),     32'(err));
        check({tag, "_hold"},          32'(cpu_reset_hold), 32'(hold));
        check({tag, "_words_written"}, 32'(words_written),  32'(words));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 13'd0);
        idle(3);
        reset = 1'b0;
        idle(2);

        // 1: good two-word frame
        good_frame();
        check_status("t1", 1'b1, 1'b0, 1'b0, 13'd2);
`ifndef PROG_LOADER_READBACK_EN
        check("t1_mem_ren_never", 32'(ren_seen), 32'd0);
`endif

        // 2: bad checksum, then recovery
        expect_write(BASE,         32'h44332211);
        expect_write(BASE + 30'd1, 32'h88776655);
        bytes = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_seq(bytes);
        check_status("t2_bad", 1'b0, 1'b1, 1'b1, 13'd2);
        good_frame();
        check_status("t2_recover", 1'b1, 1'b0, 1'b0, 13'd2);

        // 3: zero-length frame, oversize length, maximum length accepted
        bytes = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(bytes);
        check_status("t3_len0", 1'b1, 1'b0, 1'b0, 13'd0);
        bytes = '{8'hA5, 8'h01, 8'h10};
        send_seq(bytes);
        check_status("t3_len4097", 1'b0, 1'b1, 1'b1, 13'd0);
        bytes = '{8'hA5, 8'h00, 8'h10};
        send_seq(bytes);
        check("t3_len4096_no_error", 32'(load_error), 32'd0);
        check("t3_len4096_ready", 32'(rx_ready), 32'd1);
        idle(TMO);

        // 4: stall after two data bytes
        bytes = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(bytes);
        idle(TMO - 1);
        check("t4_before_timeout", 32'(load_error), 32'd0);
        idle(1);
        check_status("t4_timeout", 1'b0, 1'b1, 1'b1, 13'd0);

        // 5: reset in the third word, then reload from BASE
        expect_write(BASE,         32'h04030201);
        expect_write(BASE + 30'd1, 32'h08070605);
        bytes = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_seq(bytes);
        check("t5_words_before_reset", 32'(words_written), 32'd2);
        reset = 1'b1;
        #1;
        check("t5_rx_ready", 32'(rx_ready), 32'd1);
        check_status("t5_reset", 1'b0, 1'b0, 1'b1, 13'd0);
        idle(1);
        reset = 1'b0;
        idle(1);
        good_frame();
        check_status("t5_reload", 1'b1, 1'b0, 1'b0, 13'd2);

`ifdef PROG_LOADER_READBACK_EN
        // 6: corrupted readback of word 1
        corrupt = 1'b1;
        expect_write(BASE,         32'h44332211);
        expect_write(BASE + 30'd1, 32'h88776655);
        bytes = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88};
        send_seq(bytes);
        idle(4);
        check_status("t6_readback", 1'b0, 1'b1, 1'b1, 13'd2);
        corrupt = 1'b0;
`endif

        idle(3);
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
